// File: rtl/vcve2_dmem_responder.sv
// Memory-side responder for the req/gnt/rvalid data interface: NumIfs ports share one
// word-addressed store, with configurable grant stalls, response latency and outstanding limit.
module vcve2_dmem_responder #(
   parameter int unsigned NumIfs         = 1,
   parameter int unsigned MemWords       = 1024,
   parameter logic [31:0] BaseAddr       = 32'h0000_0000,
   parameter int unsigned RespLatency    = 1,
   parameter int unsigned MaxOutstanding = 2,
   parameter int unsigned GntStallEvery  = 0
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NumIfs-1:0]       data_req_i,
   output logic [NumIfs-1:0]       data_gnt_o,
   output logic [NumIfs-1:0]       data_rvalid_o,
   input  logic [NumIfs-1:0]       data_we_i,
   input  logic [NumIfs-1:0][3:0]  data_be_i,
   input  logic [NumIfs-1:0][31:0] data_addr_i,
   input  logic [NumIfs-1:0][31:0] data_wdata_i,
   output logic [NumIfs-1:0][31:0] data_rdata_o,
   output logic [NumIfs-1:0]       data_err_o
);

   localparam int unsigned AddrW  = (MemWords > 1) ? $clog2(MemWords) : 1;
   localparam int unsigned OutW   = $clog2(MaxOutstanding + 1);
   localparam int unsigned StallW = (GntStallEvery > 1) ? $clog2(GntStallEvery) : 1;

   localparam logic [OutW-1:0]   OutMax    = OutW'(MaxOutstanding);
   localparam logic [StallW-1:0] StallLast = StallW'((GntStallEvery > 0) ? GntStallEvery - 1 : 0);
   // Word-granular base; BaseAddr is expected to be word aligned.
   localparam logic [29:0]       BaseWord  = BaseAddr[31:2];

   logic [31:0] mem [MemWords];

   logic [NumIfs-1:0]                        in_range;
   logic [NumIfs-1:0]                        accept;
   logic [NumIfs-1:0]                        stall;
   logic [NumIfs-1:0][29:0]                  word_off;
   logic [NumIfs-1:0][31:0]                  rd_word;
   logic [NumIfs-1:0][OutW-1:0]              outst_q;
   logic [NumIfs-1:0][StallW-1:0]            stall_cnt_q;
   logic [NumIfs-1:0][RespLatency-1:0]       pipe_valid_q;
   logic [NumIfs-1:0][RespLatency-1:0]       pipe_err_q;
   logic [NumIfs-1:0][RespLatency-1:0][31:0] pipe_rdata_q;

   // NOTE: every variable gets a value on every path through this block, so no latch is inferred.
   always_comb begin
      for (int p = 0; p < NumIfs; p++) begin
         word_off[p]   = data_addr_i[p][31:2] - BaseWord;
         in_range[p]   = (data_addr_i[p] >= BaseAddr) && ({2'b00, word_off[p]} < 32'(MemWords));
         stall[p]      = (GntStallEvery > 0) && (stall_cnt_q[p] == StallLast);
         data_gnt_o[p] = rst_ni && data_req_i[p] && (outst_q[p] < OutMax) && !stall[p];
         accept[p]     = data_req_i[p] && data_gnt_o[p];
         rd_word[p]    = '0;
         if (in_range[p] && !data_we_i[p]) begin
            rd_word[p] = mem[word_off[p][AddrW-1:0]];
         end
      end
   end

   // NOTE: the backing store deliberately keeps its contents across reset, so it has no reset branch.
   // Later ports overwrite earlier ones on shared bytes because the last non-blocking write wins.
   always_ff @(posedge clk_i) begin
      for (int p = 0; p < NumIfs; p++) begin
         if (accept[p] && data_we_i[p] && in_range[p]) begin
            for (int b = 0; b < 4; b++) begin
               if (data_be_i[p][b]) begin
                  mem[word_off[p][AddrW-1:0]][8*b +: 8] <= data_wdata_i[p][8*b +: 8];
               end
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outst_q      <= '0;
         stall_cnt_q  <= '0;
         pipe_valid_q <= '0;
         pipe_err_q   <= '0;
         pipe_rdata_q <= '0;
      end else begin
         for (int p = 0; p < NumIfs; p++) begin
            if (data_req_i[p] && (GntStallEvery > 0)) begin
               stall_cnt_q[p] <= stall[p] ? '0 : stall_cnt_q[p] + 1'b1;
            end

            // A retiring response frees its slot only from the next cycle on.
            case ({accept[p], data_rvalid_o[p]})
               2'b10:   outst_q[p] <= outst_q[p] + 1'b1;
               2'b01:   outst_q[p] <= outst_q[p] - 1'b1;
               default: outst_q[p] <= outst_q[p];
            endcase

            for (int s = RespLatency - 1; s > 0; s--) begin
               pipe_valid_q[p][s] <= pipe_valid_q[p][s-1];
               pipe_err_q[p][s]   <= pipe_err_q[p][s-1];
               pipe_rdata_q[p][s] <= pipe_rdata_q[p][s-1];
            end
            pipe_valid_q[p][0] <= accept[p];
            pipe_err_q[p][0]   <= accept[p] && !in_range[p];
            pipe_rdata_q[p][0] <= accept[p] ? rd_word[p] : '0;
         end
      end
   end

   always_comb begin
      for (int p = 0; p < NumIfs; p++) begin
         data_rvalid_o[p] = pipe_valid_q[p][RespLatency-1];
         data_rdata_o[p]  = data_rvalid_o[p] ? pipe_rdata_q[p][RespLatency-1] : '0;
         data_err_o[p]    = data_rvalid_o[p] && pipe_err_q[p][RespLatency-1];
      end
   end

endmodule

// File: tb/tb_vcve2_dmem_responder.sv
// Directed bench for vcve2_dmem_responder: three instances cover basic access/collisions,
// the outstanding limit with long latency, and the grant-stall pattern.
module tb_vcve2_dmem_responder;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Instance A: two ports, latency 1, no stalls.
   logic [1:0]       a_req, a_gnt, a_rvalid, a_we, a_err;
   logic [1:0][3:0]  a_be;
   logic [1:0][31:0] a_addr, a_wdata, a_rdata;

   // Instance B: one port, latency 4, two outstanding.
   logic [0:0]       b_req, b_gnt, b_rvalid, b_we, b_err;
   logic [0:0][3:0]  b_be;
   logic [0:0][31:0] b_addr, b_wdata, b_rdata;

   // Instance C: one port, latency 1, stall every third requesting cycle.
   logic [0:0]       c_req, c_gnt, c_rvalid, c_we, c_err;
   logic [0:0][3:0]  c_be;
   logic [0:0][31:0] c_addr, c_wdata, c_rdata;

   vcve2_dmem_responder #(
      .NumIfs(2), .MemWords(1024), .BaseAddr(32'h0), .RespLatency(1),
      .MaxOutstanding(2), .GntStallEvery(0)
   ) dut_a (
      .clk_i(clk), .rst_ni(rst_n),
      .data_req_i(a_req), .data_gnt_o(a_gnt), .data_rvalid_o(a_rvalid),
      .data_we_i(a_we), .data_be_i(a_be), .data_addr_i(a_addr),
      .data_wdata_i(a_wdata), .data_rdata_o(a_rdata), .data_err_o(a_err)
   );

   vcve2_dmem_responder #(
      .NumIfs(1), .MemWords(1024), .BaseAddr(32'h0), .RespLatency(4),
      .MaxOutstanding(2), .GntStallEvery(0)
   ) dut_b (
      .clk_i(clk), .rst_ni(rst_n),
      .data_req_i(b_req), .data_gnt_o(b_gnt), .data_rvalid_o(b_rvalid),
      .data_we_i(b_we), .data_be_i(b_be), .data_addr_i(b_addr),
      .data_wdata_i(b_wdata), .data_rdata_o(b_rdata), .data_err_o(b_err)
   );

   vcve2_dmem_responder #(
      .NumIfs(1), .MemWords(1024), .BaseAddr(32'h0), .RespLatency(1),
      .MaxOutstanding(2), .GntStallEvery(3)
   ) dut_c (
      .clk_i(clk), .rst_ni(rst_n),
      .data_req_i(c_req), .data_gnt_o(c_gnt), .data_rvalid_o(c_rvalid),
      .data_we_i(c_we), .data_be_i(c_be), .data_addr_i(c_addr),
      .data_wdata_i(c_wdata), .data_rdata_o(c_rdata), .data_err_o(c_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Requester protocol monitor: once req is seen without gnt, req and attributes must hold.
   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } attr_t;

   attr_t      prev_attr [4];
   logic [3:0] pending = '0;

   always @(negedge clk) begin
      attr_t      cur [4];
      logic [3:0] req, gnt;
      req    = {c_req[0], b_req[0], a_req[1], a_req[0]};
      gnt    = {c_gnt[0], b_gnt[0], a_gnt[1], a_gnt[0]};
      cur[0] = {a_we[0], a_be[0], a_addr[0], a_wdata[0]};
      cur[1] = {a_we[1], a_be[1], a_addr[1], a_wdata[1]};
      cur[2] = {b_we[0], b_be[0], b_addr[0], b_wdata[0]};
      cur[3] = {c_we[0], c_be[0], c_addr[0], c_wdata[0]};
      for (int i = 0; i < 4; i++) begin
         if (pending[i] && (!req[i] || cur[i] !== prev_attr[i])) begin
            bad++;
            $display("FAIL protocol requester %0d: req or attributes changed before gnt", i);
         end
         pending[i]   = req[i] && !gnt[i];
         prev_attr[i] = cur[i];
      end
   end

   typedef struct packed {
      logic        port;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [14];

   // Single transaction on instance A; starts and ends just after a rising edge.
   task automatic txn(input vec_t v, input string name);
      int p;
      p          = int'(v.port);
      a_req[p]   = 1'b1;
      a_we[p]    = v.we;
      a_be[p]    = v.be;
      a_addr[p]  = v.addr;
      a_wdata[p] = v.wdata;
      #1;
      check({name, " gnt"}, 32'(a_gnt[p]), 32'd1);
      @(posedge clk); #1;
      a_req[p] = 1'b0;
      check({name, " rvalid"}, 32'(a_rvalid[p]), 32'd1);
      check({name, " rdata"}, a_rdata[p], v.exp_rdata);
      check({name, " err"}, 32'(a_err[p]), 32'(v.exp_err));
      @(posedge clk); #1;
      check({name, " rvalid one pulse"}, 32'(a_rvalid[p]), 32'd0);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      logic [14:0] exp_gnt_b;
      logic [14:0] exp_rv_b;
      logic [7:0]  exp_gnt_c;
      logic [7:0]  exp_rv_c;
      int          n_gnt, n_rv, late_rv;

      //            port  we    be     addr          wdata         rdata         err
      vecs[0]  = '{1'b0, 1'b1, 4'hF, 32'h0000_0010, 32'hDEADBEEF, 32'h0000_0000, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'h0000_0000, 32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 4'h5, 32'h0000_0010, 32'h11223344, 32'h0000_0000, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'hDE22BE44, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 4'hF, 32'h0000_0012, 32'h0000_0000, 32'hDE22BE44, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 4'hF, 32'h0000_0000, 32'h01020304, 32'h0000_0000, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 4'hF, 32'h0000_1000, 32'h0000_0000, 32'h0000_0000, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, 4'hF, 32'h0000_1000, 32'h12345678, 32'h0000_0000, 1'b1};
      vecs[8]  = '{1'b0, 1'b0, 4'hF, 32'h0000_0000, 32'h0000_0000, 32'h01020304, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0FFC, 32'hCAFEF00D, 32'h0000_0000, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 4'hF, 32'h0000_0FFC, 32'h0000_0000, 32'hCAFEF00D, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 4'h0, 32'h0000_0010, 32'hFFFFFFFF, 32'h0000_0000, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0000_0000, 32'hDE22BE44, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 4'hF, 32'h0000_1004, 32'h0000_0000, 32'h0000_0000, 1'b1};

      // Bit c is the expected value in cycle c of the sequence.
      exp_gnt_b = 15'b000010001100011;
      exp_rv_b  = 15'b100011000110000;
      exp_gnt_c = 8'b01011011;
      exp_rv_c  = 8'b10110110;

      rst_n = 1'b0;
      a_req = '0; a_we = '0; a_be = '0; a_addr = '0; a_wdata = '0;
      b_req = '0; b_we = '0; b_be = '0; b_addr = '0; b_wdata = '0;
      c_req = '0; c_we = '0; c_be = '0; c_addr = '0; c_wdata = '0;

      repeat (2) @(posedge clk);
      #1;
      check("reset a_gnt", 32'(a_gnt), 32'd0);
      check("reset a_rvalid", 32'(a_rvalid), 32'd0);
      check("reset a_rdata0", a_rdata[0], 32'd0);
      check("reset a_rdata1", a_rdata[1], 32'd0);
      check("reset a_err", 32'(a_err), 32'd0);
      check("reset b_rvalid", 32'(b_rvalid), 32'd0);
      check("reset c_rvalid", 32'(c_rvalid), 32'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 14; i++) begin
         txn(vecs[i], $sformatf("vec%0d", i));
      end

      // Two ports write the same word in one cycle; port 1 wins its bytes.
      a_req = 2'b11; a_we = 2'b11;
      a_be[0] = 4'hF; a_addr[0] = 32'h20; a_wdata[0] = 32'hAAAAAAAA;
      a_be[1] = 4'h3; a_addr[1] = 32'h20; a_wdata[1] = 32'h55555555;
      #1;
      check("collision gnt", 32'(a_gnt), 32'd3);
      tick();
      a_req = 2'b00;
      check("collision rvalid", 32'(a_rvalid), 32'd3);
      check("collision err", 32'(a_err), 32'd0);
      tick();
      txn('{1'b0, 1'b0, 4'hF, 32'h20, 32'h0, 32'hAAAA5555, 1'b0}, "collision merge");

      // Same-cycle read on port 1 of a word port 0 is writing sees the old value.
      a_req = 2'b11; a_we = 2'b01;
      a_be[0] = 4'hF; a_addr[0] = 32'h20; a_wdata[0] = 32'h13572468;
      a_be[1] = 4'h0; a_addr[1] = 32'h20; a_wdata[1] = 32'h0;
      #1;
      check("rbw gnt", 32'(a_gnt), 32'd3);
      tick();
      a_req = 2'b00;
      check("rbw rvalid", 32'(a_rvalid), 32'd3);
      check("rbw old value", a_rdata[1], 32'hAAAA5555);
      tick();
      txn('{1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 32'h13572468, 1'b0}, "rbw new value");

      // Outstanding limit with latency 4; req held for cycles 0..10.
      b_we = 1'b1; b_be[0] = 4'h0; b_addr[0] = 32'h40; b_wdata[0] = 32'h0;
      for (int c = 0; c < 15; c++) begin
         b_req[0] = (c < 11);
         #1;
         check($sformatf("limit gnt c%0d", c), 32'(b_gnt), 32'(exp_gnt_b[c]));
         check($sformatf("limit rvalid c%0d", c), 32'(b_rvalid), 32'(exp_rv_b[c]));
         @(posedge clk); #1;
      end

      // Stall pattern: req held until the 5th grant.
      c_we = 1'b1; c_be[0] = 4'h0; c_addr[0] = 32'h0; c_wdata[0] = 32'h0;
      n_gnt = 0; n_rv = 0;
      for (int c = 0; c < 8; c++) begin
         c_req[0] = (c < 7);
         #1;
         check($sformatf("stall gnt c%0d", c), 32'(c_gnt), 32'(exp_gnt_c[c]));
         check($sformatf("stall rvalid c%0d", c), 32'(c_rvalid), 32'(exp_rv_c[c]));
         if (c_gnt[0]) n_gnt++;
         if (c_rvalid[0]) n_rv++;
         @(posedge clk); #1;
      end
      check("stall grant count", 32'(n_gnt), 32'd5);
      check("stall response count", 32'(n_rv), 32'd5);

      // Two transactions in flight on B, then reset drops them.
      b_req[0] = 1'b1;
      #1;
      check("inflight gnt0", 32'(b_gnt), 32'd1);
      tick();
      #1;
      check("inflight gnt1", 32'(b_gnt), 32'd1);
      tick();
      b_req[0] = 1'b0;
      #2;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      late_rv = 0;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (b_rvalid[0]) late_rv++;
         @(posedge clk); #1;
      end
      check("no rvalid after reset", 32'(late_rv), 32'd0);
      b_req[0] = 1'b1;
      #1;
      check("post-reset gnt0", 32'(b_gnt), 32'd1);
      tick();
      #1;
      check("post-reset gnt1", 32'(b_gnt), 32'd1);
      tick();
      b_req[0] = 1'b0;
      repeat (6) tick();

      txn('{1'b0, 1'b0, 4'hF, 32'h20, 32'h0, 32'h13572468, 1'b0}, "memory kept over reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vcve2_dmem_responder.md
Name: vcve2_dmem_responder

Overview:
Memory-side responder for the core's req/gnt/rvalid data interface. It terminates the NumIfs data ports driven by the data-memory switch and serves them from a shared word-addressed backing store. Grant stall patterns, response latency and the outstanding-transaction limit are configurable, so the switch's port-sharing and response-steering logic can be driven against realistic memory timing. It serves both as the on-chip TCM and as the bench memory model.

Parameters:
NumIfs, 1, number of independent data ports (1..3)
MemWords, 1024, backing store depth in 32-bit words
BaseAddr, 32'h0000_0000, byte address of word 0
RespLatency, 1, cycles from the granting edge to rvalid; must be >=1
MaxOutstanding, 2, granted-but-unanswered transactions allowed per port; must be >=1
GntStallEvery, 0, 0 = never stall; N>0 = withhold gnt on every Nth requesting cycle per port

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
data_req_i  in  [NumIfs-1:0]  request valid per port
data_gnt_o  out  [NumIfs-1:0]  request accepted this cycle
data_rvalid_o  out  [NumIfs-1:0]  response valid
data_we_i  in  [NumIfs-1:0]  1 = write, 0 = read
data_be_i  in  [NumIfs-1:0][3:0]  byte enables
data_addr_i  in  [NumIfs-1:0][31:0]  byte address; bits [1:0] ignored
data_wdata_i  in  [NumIfs-1:0][31:0]  write data
data_rdata_o  out  [NumIfs-1:0][31:0]  read data, valid with rvalid
data_err_o  out  [NumIfs-1:0]  bus error, valid with rvalid

Behaviour:
- Reset, asynchronous on rst_ni low: gnt, rvalid, err = 0; rdata = 0; response pipelines, outstanding counters and stall counters cleared. Memory contents are not reset. Asserting reset mid-operation drops all in-flight responses.
- Grant is combinational. For each port p: gnt[p] = req[p] && (outstanding[p] < MaxOutstanding) && !stall[p]. A response retiring in the same cycle does not free a slot until the next cycle.
- Stall counter, per port, applies when GntStallEvery>0:
  - Increments on each cycle with req[p]=1.
  - stall[p] = 1 when the counter == GntStallEvery-1; the counter then wraps to 0.
  - Cycles without a request hold the counter. Cycles blocked by the outstanding limit still count.
- Transaction accept: occurs at the rising edge where req && gnt.
- Address check: word index = (addr - BaseAddr) >> 2. The access is in range iff addr >= BaseAddr and index < MemWords.
  - Out-of-range: no memory access; response carries err=1 and rdata=0.
- Write (in range): bytes with be[i]=1 are updated at the accept edge. The response has rdata=0, err=0. be=0 is a legal no-op write that still gets a response.
- Read (in range): the word is sampled at the accept edge with read-before-write semantics. A same-cycle write to the same word from any port is not visible to the read. be is ignored and all 32 bits are returned.
- Multi-port write collision on the same word: ports are applied in ascending index order, so the highest-index port wins on overlapping bytes. Non-overlapping bytes from all ports are merged.
- Response pipeline, per port:
  - Shift register of depth RespLatency holding {valid, rdata, err}.
  - rvalid[p] is asserted exactly RespLatency cycles after the accept edge, for one cycle per transaction.
  - Responses are strictly in order. There is no rvalid backpressure.
- Outstanding counter, per port:
  - +1 on accept, -1 on rvalid, unchanged when both occur in the same cycle.
  - Range 0..MaxOutstanding; it can never overflow because gnt is gated by the limit.
- Output gating: rdata and err are forced to 0 whenever rvalid is 0.
- Port independence: ports never block one another, and every port may be granted in the same cycle.
- Requester protocol: a requester must hold req and all attributes stable until gnt. Changing them earlier is illegal, and the bench must assert this.

Test Plan:
1. Latency 1, port 0: write addr 0x10, be=4'b1111, wdata 0xDEADBEEF; then read 0x10 -> gnt in the request cycle; read rvalid one cycle after gnt with rdata 0xDEADBEEF, err 0.
2. Byte enables: word holds 0xDEADBEEF; write be=4'b0101, wdata 0x11223344 -> a subsequent read returns 0xDE22BE44.
3. Out of range, MemWords=1024, BaseAddr=0: read 0x1000 -> rvalid with err=1, rdata=0, memory unchanged; write 0x1000 behaves the same.
4. Outstanding limit, RespLatency=4, MaxOutstanding=2, req held continuously -> gnt on cycles 0 and 1, low on cycles 2-4; rvalid on cycles 4 and 5; next gnt on cycle 5.
5. Stall pattern, GntStallEvery=3, continuous back-to-back reads -> gnt pattern 1,1,0,1,1,0; exactly one rvalid per granted request, in order.
6. NumIfs=2 collision: same cycle, port 0 writes 0xAAAAAAAA with be=4'b1111 and port 1 writes 0x55555555 with be=4'b0011 to word 0x20 -> a subsequent read returns 0xAAAA5555. In a separate cycle, a same-cycle read on port 1 of a word being written by port 0 returns the old value. Finally, assert reset with responses in flight -> no rvalid after reset release.
